// File: rtl/bit_serial_adder.sv
// ---------------------------------------------------------------------------
// bit_serial_adder
//
// Sequential WIDTH-bit adder. Operands are captured on the accepting edge and
// added one bit per clock, LSB first, through a single one-bit full-adder
// slice (two half-adder cells plus an OR) with a registered carry. The sum is
// assembled in a shift register and published, together with the carry-out,
// only when the last bit has been processed.
//
// Optional feature macro: SERIAL_SUB_EN
//   defined   : adds the 'sub' port; sub=1 computes a + ~b + 1 (cin ignored),
//               cout=1 then means "no borrow" (a >= b unsigned).
//   undefined : add only, no 'sub' port.
//
// Ports
//   clk    in   1      clock, all state updates on the rising edge
//   rst    in   1      synchronous, active-high reset (priority over start)
//   start  in   1      request, sampled only in IDLE
//   a      in   WIDTH  operand A, sampled on the accepting edge
//   b      in   WIDTH  operand B, sampled on the accepting edge
//   cin    in   1      carry-in, sampled on the accepting edge
//   sub    in   1      subtract select (SERIAL_SUB_EN only)
//   busy   out  1      high while in RUN or DONE
//   done   out  1      one-cycle pulse, s/cout newly updated
//   s      out  WIDTH  registered sum
//   cout   out  1      registered carry-out
// ---------------------------------------------------------------------------
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rs_d;
    logic             carry_q;
    logic             carry_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    // Effective subtract select; a constant 0 when the feature is compiled out,
    // so the load path reduces to a plain add.
    logic sub_eff;
`ifdef SERIAL_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    // Values loaded on the accepting edge: subtraction is a + ~b + 1.
    logic [WIDTH-1:0] rb_load;
    logic             carry_load;
    assign rb_load    = sub_eff ? ~b : b;
    assign carry_load = sub_eff ? 1'b1 : cin;

    // One-bit full-adder slice built from two half-adder cells and an OR.
    logic ha1_s, ha1_c, ha2_c, slice_sum;
    assign ha1_s     = ra_q[0] ^ rb_q[0];
    assign ha1_c     = ra_q[0] & rb_q[0];
    assign slice_sum = ha1_s ^ carry_q;
    assign ha2_c     = ha1_s & carry_q;
    assign carry_d   = ha1_c | ha2_c;

    // Sum bits enter at the MSB so that after WIDTH shifts the LSB-first
    // stream sits in its natural bit order.
    assign rs_d = {slice_sum, rs_q[WIDTH-1:1]};

    // NOTE: every state register below is assigned with <= so all of them
    // sample the pre-edge values; blocking = here would let later statements
    // see half-updated state and break the shift/carry relationship.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rs_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= rb_load;
                        carry_q <= carry_load;
                        rs_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    ra_q    <= ra_q >> 1;
                    rb_q    <= rb_q >> 1;
                    rs_q    <= rs_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        // Last slice: publish the completed sum and final carry.
                        s_q     <= rs_d;
                        cout_q  <= carry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_adder
//
// Directed testbench for bit_serial_adder (WIDTH=8). Each scenario task drives
// its own stimulus and compares DUT outputs against hand-computed values.
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic set_sub(input logic v);
`ifdef SERIAL_SUB_EN
        sub = v;
`else
        if (v) $display("note: sub requested but SERIAL_SUB_EN not defined");
`endif
    endtask

    // Wait for done, counting edges from the accepting edge (inclusive).
    task automatic wait_done(input int start_lat, output int lat);
        lat = start_lat;
        for (int i = 0; i < 4 * WIDTH; i++) begin
            if (done) return;
            tick();
            lat++;
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_done: done not seen within %0d edges", 4 * WIDTH);
        end
    endtask

    // Accept one operation and wait for its done pulse; returns latency.
    task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vcin, input logic vsub, output int lat);
        a = va; b = vb; cin = vcin; set_sub(vsub);
        start = 1'b1;
        tick();                       // accepting edge E0
        start = 1'b0;
        wait_done(1, lat);
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] exp_s,
                                input logic exp_c);
        n_checks++;
        if (s !== exp_s) begin
            n_fail++;
            $display("FAIL %s sum: got %h expected %h", name, s, exp_s);
        end
        n_checks++;
        if (cout !== exp_c) begin
            n_fail++;
            $display("FAIL %s cout: got %b expected %b", name, cout, exp_c);
        end
    endtask

    task automatic test_reset();
        int seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; set_sub(1'b0);
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b expected 0", done); end
        check_result("reset", 8'h00, 1'b0);
        rst = 1'b0;
        tick();

        // Abort: reset during RUN cycle 3.
        a = 8'h5A; b = 8'h3C; cin = 1'b1; start = 1'b1;
        tick();                       // E0
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort busy_after_accept: got %b expected 1", busy); end
        tick(); tick();               // now in RUN cycle 3
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        seen_done = 0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            if (done === 1'b1) seen_done++;
            tick();
        end
        n_checks++; if (seen_done != 0) begin n_fail++; $display("FAIL abort done_pulses: got %0d expected 0", seen_done); end
        check_result("abort", 8'h00, 1'b0);
    endtask

    task automatic test_add();
        int lat;
        run_op(8'h5A, 8'h3C, 1'b1, 1'b0, lat);
        n_checks++; if (lat != WIDTH + 1) begin n_fail++; $display("FAIL add latency: got %0d expected %0d", lat, WIDTH + 1); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add busy_in_done: got %b expected 1", busy); end
        check_result("add_5A_3C", 8'h97, 1'b0);
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL add done_width: got %b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_carry();
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        check_result("wrap_FF_01", 8'h00, 1'b1);
        tick();
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, lat);
        check_result("wrap_FF_FF_c1", 8'hFF, 1'b1);
        tick();
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] op_a [3] = '{8'h12, 8'h80, 8'hA5};
        logic [WIDTH-1:0] op_b [3] = '{8'h34, 8'h80, 8'h5A};
        logic             op_c [3] = '{1'b0, 1'b1, 1'b0};
        logic [WIDTH-1:0] ex_s [3] = '{8'h46, 8'h01, 8'hFF};
        logic             ex_c [3] = '{1'b0, 1'b1, 1'b0};
        int lat;
        int last_done;
        last_done = -1;
        a = op_a[0]; b = op_b[0]; cin = op_c[0]; set_sub(1'b0);
        start = 1'b1;
        tick();                       // first accept
        for (int k = 0; k < 3; k++) begin
            // Scramble operands mid-RUN; they must have no effect.
            a = ~op_a[k]; b = op_b[k] ^ 8'h5F; cin = ~op_c[k];
            wait_done(1, lat);
            n_checks++; if (lat != WIDTH + 1) begin n_fail++; $display("FAIL b2b%0d latency: got %0d expected %0d", k, lat, WIDTH + 1); end
            if (last_done >= 0) begin
                n_checks++;
                if (cycle - last_done != WIDTH + 2) begin
                    n_fail++;
                    $display("FAIL b2b%0d spacing: got %0d expected %0d", k, cycle - last_done, WIDTH + 2);
                end
            end
            last_done = cycle;
            check_result($sformatf("b2b%0d", k), ex_s[k], ex_c[k]);
            if (k < 2) begin
                a = op_a[k+1]; b = op_b[k+1]; cin = op_c[k+1];
            end else begin
                start = 1'b0;
            end
            tick();                   // DONE -> IDLE
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL b2b%0d done_width: got %b expected 0", k, done); end
            tick();                   // accept next (start held) or stay idle
        end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_hold();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 8'(i * 37 + 3); b = 8'(~(i * 11)); cin = i[0];
            tick();
            check_result($sformatf("hold%0d", i), 8'hFF, 1'b0);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold%0d busy: got %b expected 0", i, busy); end
        end
    endtask

`ifdef SERIAL_SUB_EN
    task automatic test_sub();
        int lat;
        run_op(8'h10, 8'h01, 1'b1, 1'b1, lat);
        check_result("sub_10_01", 8'h0F, 1'b1);
        tick();
        run_op(8'h01, 8'h02, 1'b0, 1'b1, lat);
        check_result("sub_01_02", 8'hFF, 1'b0);
        tick();
        set_sub(1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_back_to_back();
        test_hold();
`ifdef SERIAL_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
